// File: rtl/cont_mod_updown.sv
// Modulo-N up/down counter with clear/load, wrap or saturate, sticky overflow
// flag and a zero-latency terminal count for building cascaded counter chains.
module cont_mod_updown #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 200,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_dn,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             ovf
);

  // Computed in 64 bits so MODULUS = 2**WIDTH (WIDTH up to 32) cannot overflow.
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);

  logic at_top;
  logic at_bottom;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > TOP) ? TOP : v;
  endfunction

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    if (v == TOP)
      return SATURATE ? v : '0;
    return v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    if (v == '0)
      return SATURATE ? v : TOP;
    return v - WIDTH'(1);
  endfunction

  assign at_top    = (Q == TOP);
  assign at_bottom = (Q == '0);

  // Deliberately not gated by clear/load so a chain stays purely combinational.
  assign TC = enable & ((up_dn & at_top) | (~up_dn & at_bottom));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q   <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      Q   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      Q <= clamp_load(load_value);
    end else if (enable) begin
      if (up_dn) begin
        Q <= step_up(Q);
        if (at_top)
          ovf <= 1'b1;
      end else begin
        Q <= step_down(Q);
        if (at_bottom)
          ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cont_mod_updown.sv
// Bench for cont_mod_updown: wrap, saturate and binary-modulus instances plus a
// two-digit decimal cascade, all checked against an arithmetic reference model.
module tb_cont_mod_updown;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       clear = 1'b0, load = 1'b0, enable = 1'b0, up_dn = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic [7:0] qw, qs;
  logic [2:0] qb;
  logic       tcw, tcs, tcb, ovw, ovs, ovb;

  logic       c_clear = 1'b0, c_en = 1'b0, c_up = 1'b0, c_load = 1'b0;
  logic [3:0] c_lv = 4'd0;
  logic [3:0] q0, q1;
  logic       tc0, tc1, ov0, ov1;

  int checks = 0;
  int errors = 0;

  // reference model state
  int mw, ms, mb, cn;
  bit ow, os, ob, co0, co1;

  always #5 clk = ~clk;

  cont_mod_updown #(.WIDTH(8), .MODULUS(200), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_dn(up_dn), .Q(qw), .TC(tcw), .ovf(ovw));

  cont_mod_updown #(.WIDTH(8), .MODULUS(200), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_dn(up_dn), .Q(qs), .TC(tcs), .ovf(ovs));

  cont_mod_updown #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value[2:0]),
    .enable(enable), .up_dn(up_dn), .Q(qb), .TC(tcb), .ovf(ovb));

  cont_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dig0 (
    .clk(clk), .reset_n(reset_n), .clear(c_clear), .load(c_load), .load_value(c_lv),
    .enable(c_en), .up_dn(c_up), .Q(q0), .TC(tc0), .ovf(ov0));

  cont_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dig1 (
    .clk(clk), .reset_n(reset_n), .clear(c_clear), .load(c_load), .load_value(c_lv),
    .enable(tc0), .up_dn(c_up), .Q(q1), .TC(tc1), .ovf(ov1));

  task automatic model_step(inout int q, inout bit o, input int m, input bit sat, input int lv);
    int nxt;
    if (clear) begin
      q = 0;
      o = 0;
    end else if (load) begin
      q = (lv < m) ? lv : m - 1;
    end else if (enable) begin
      nxt = up_dn ? q + 1 : q - 1;
      if (nxt < 0 || nxt >= m) begin
        o = 1;
        nxt = sat ? q : (nxt + m) % m;
      end
      q = nxt;
    end
  endtask

  // The cascade is modelled as one decimal number 0..99.
  task automatic casc_step();
    int d0;
    d0 = cn % 10;
    if (c_clear) begin
      cn = 0; co0 = 0; co1 = 0;
    end else if (c_en) begin
      if (c_up) begin
        if (d0 == 9) co0 = 1;
        if (cn == 99) co1 = 1;
        cn = (cn + 1) % 100;
      end else begin
        if (d0 == 0) co0 = 1;
        if (cn == 0) co1 = 1;
        cn = (cn + 99) % 100;
      end
    end
  endtask

  function automatic bit exp_tc(input int q, input int m);
    return enable && ((up_dn && q == m - 1) || (!up_dn && q == 0));
  endfunction

  task automatic model_reset();
    mw = 0; ms = 0; mb = 0; cn = 0;
    ow = 0; os = 0; ob = 0; co0 = 0; co1 = 0;
  endtask

  task automatic tick();
    if (reset_n) begin
      model_step(mw, ow, 200, 1'b0, int'(load_value));
      model_step(ms, os, 200, 1'b1, int'(load_value));
      model_step(mb, ob, 8, 1'b0, int'(load_value) % 8);
      casc_step();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (qw !== 8'd0 || ovw !== 1'b0) begin
      errors++; $display("FAIL reset_w q=%0d ovf=%0b expected 0/0", qw, ovw);
    end
    checks++;
    if (qs !== 8'd0 || qb !== 3'd0 || q0 !== 4'd0 || q1 !== 4'd0) begin
      errors++; $display("FAIL reset_others qs=%0d qb=%0d q0=%0d q1=%0d expected 0", qs, qb, q0, q1);
    end
    checks++;
    if (tcw !== 1'b0) begin
      errors++; $display("FAIL reset_tc_idle got %0b expected 0", tcw);
    end
    enable = 1'b1; up_dn = 1'b0;
    #1;
    checks++;
    if (tcw !== 1'b1 || tcb !== 1'b1) begin
      errors++; $display("FAIL reset_tc_down got %0b/%0b expected 1/1", tcw, tcb);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (tcw !== (i == 199)) begin
        errors++; $display("FAIL up_tc q=%0d got %0b expected %0b", i, tcw, (i == 199));
      end
      tick();
      checks++;
      if (qw !== 8'((i + 1) % 200) || ovw !== (i == 199)) begin
        errors++; $display("FAIL up_q step=%0d got %0d/%0b expected %0d/%0b", i, qw, ovw, (i + 1) % 200, (i == 199));
      end
    end
    checks++;
    if (qs !== 8'(ms) || ovs !== os || qb !== 3'(mb) || ovb !== ob) begin
      errors++; $display("FAIL up_side qs=%0d/%0d qb=%0d/%0d expected %0d/%0b %0d/%0b", qs, ovs, qb, ovb, ms, os, mb, ob);
    end
    enable = 1'b0;
  endtask

  task automatic test_down();
    int seq[4] = '{2, 1, 0, 199};
    int cur;
    clear = 1'b1; tick(); clear = 1'b0;
    load = 1'b1; load_value = 8'd3; tick(); load = 1'b0;
    checks++;
    if (qw !== 8'd3) begin
      errors++; $display("FAIL down_load got %0d expected 3", qw);
    end
    cur = 3;
    enable = 1'b1; up_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tcw !== (cur == 0)) begin
        errors++; $display("FAIL down_tc q=%0d got %0b expected %0b", cur, tcw, (cur == 0));
      end
      tick();
      cur = seq[k];
      checks++;
      if (qw !== 8'(cur) || ovw !== (k == 3)) begin
        errors++; $display("FAIL down_q step=%0d got %0d/%0b expected %0d/%0b", k, qw, ovw, cur, (k == 3));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_saturate();
    clear = 1'b1; tick(); clear = 1'b0;
    load = 1'b1; load_value = 8'd198; tick(); load = 1'b0;
    enable = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (qs !== 8'd199 || tcs !== 1'b1 || ovs !== (k >= 1)) begin
        errors++; $display("FAIL sat_up step=%0d got q=%0d tc=%0b ovf=%0b expected 199/1/%0b", k, qs, tcs, ovs, (k >= 1));
      end
    end
    up_dn = 1'b0;
    tick();
    checks++;
    if (qs !== 8'd198 || ovs !== 1'b1) begin
      errors++; $display("FAIL sat_down got %0d/%0b expected 198/1", qs, ovs);
    end
    checks++;
    if (qw !== 8'(mw) || ovw !== ow) begin
      errors++; $display("FAIL sat_wrapside got %0d/%0b expected %0d/%0b", qw, ovw, mw, ow);
    end
    enable = 1'b0;
  endtask

  task automatic test_priority();
    checks++;
    if (ovw !== 1'b1) begin
      errors++; $display("FAIL prio_pre_ovf got %0b expected 1", ovw);
    end
    clear = 1'b1; load = 1'b1; enable = 1'b1; up_dn = 1'b1; load_value = 8'd50;
    tick();
    checks++;
    if (qw !== 8'd0 || ovw !== 1'b0 || qs !== 8'd0 || ovs !== 1'b0) begin
      errors++; $display("FAIL prio_clear got %0d/%0b %0d/%0b expected 0/0 0/0", qw, ovw, qs, ovs);
    end
    clear = 1'b0; load_value = 8'd250;
    tick();
    checks++;
    if (qw !== 8'd199 || qs !== 8'd199 || qb !== 3'd2) begin
      errors++; $display("FAIL prio_clamp got %0d/%0d/%0d expected 199/199/2", qw, qs, qb);
    end
    checks++;
    if (tcw !== 1'b1) begin
      errors++; $display("FAIL prio_tc_load got %0b expected 1", tcw);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (tcw !== 1'b1 || tcs !== 1'b1) begin
      errors++; $display("FAIL prio_tc_clear got %0b/%0b expected 1/1", tcw, tcs);
    end
    tick();
    clear = 1'b0; load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_async_reset();
    clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 120; i++) tick();
    checks++;
    if (qw !== 8'd120) begin
      errors++; $display("FAIL areset_pre got %0d expected 120", qw);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (qw !== 8'd0 || ovw !== 1'b0 || qs !== 8'd0 || qb !== 3'd0) begin
      errors++; $display("FAIL areset_now got %0d/%0b %0d %0d expected 0/0 0 0", qw, ovw, qs, qb);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (qw !== 8'd5 || ovw !== 1'b0) begin
      errors++; $display("FAIL areset_resume got %0d/%0b expected 5/0", qw, ovw);
    end
    enable = 1'b0;
  endtask

  task automatic test_cascade();
    c_clear = 1'b1; tick(); c_clear = 1'b0;
    c_en = 1'b1; c_up = 1'b1;
    for (int n = 0; n < 100; n++) begin
      checks++;
      if (q0 !== 4'(n % 10) || q1 !== 4'(n / 10) || tc0 !== (n % 10 == 9)) begin
        errors++; $display("FAIL casc n=%0d got %0d%0d tc0=%0b expected %0d tc0=%0b", n, q1, q0, tc0, n, (n % 10 == 9));
      end
      if (n == 99) begin
        checks++;
        if (tc0 !== 1'b1 || tc1 !== 1'b1) begin
          errors++; $display("FAIL casc_tc99 got %0b/%0b expected 1/1", tc0, tc1);
        end
      end
      tick();
    end
    checks++;
    if (q0 !== 4'd0 || q1 !== 4'd0 || ov1 !== 1'b1) begin
      errors++; $display("FAIL casc_wrap got %0d%0d ovf=%0b expected 00 ovf=1", q1, q0, ov1);
    end
    c_en = 1'b0;
  endtask

  task automatic test_random();
    int pick;
    int lvals[5] = '{0, 198, 199, 200, 255};
    for (int i = 0; i < 400; i++) begin
      clear  = ($urandom_range(0, 31) == 0);
      load   = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 3) != 0);
      up_dn  = 1'($urandom_range(0, 1));
      pick   = int'($urandom_range(0, 5));
      load_value = (pick < 5) ? 8'(lvals[pick]) : 8'($urandom);
      c_clear = ($urandom_range(0, 63) == 0);
      c_en    = ($urandom_range(0, 3) != 0);
      c_up    = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (tcw !== exp_tc(mw, 200) || tcs !== exp_tc(ms, 200) || tcb !== exp_tc(mb, 8)) begin
        errors++; $display("FAIL rnd_tc i=%0d got %0b%0b%0b expected %0b%0b%0b", i, tcw, tcs, tcb,
                           exp_tc(mw, 200), exp_tc(ms, 200), exp_tc(mb, 8));
      end
      checks++;
      if (tc0 !== (c_en && ((c_up && cn % 10 == 9) || (!c_up && cn % 10 == 0))) ||
          tc1 !== (c_en && ((c_up && cn == 99) || (!c_up && cn == 0)))) begin
        errors++; $display("FAIL rnd_casc_tc i=%0d n=%0d got %0b%0b", i, cn, tc0, tc1);
      end
      tick();
      checks++;
      if (qw !== 8'(mw) || ovw !== ow || qs !== 8'(ms) || ovs !== os || qb !== 3'(mb) || ovb !== ob) begin
        errors++; $display("FAIL rnd_q i=%0d got %0d/%0b %0d/%0b %0d/%0b expected %0d/%0b %0d/%0b %0d/%0b",
                           i, qw, ovw, qs, ovs, qb, ovb, mw, ow, ms, os, mb, ob);
      end
      checks++;
      if (q0 !== 4'(cn % 10) || q1 !== 4'(cn / 10) || ov0 !== co0 || ov1 !== co1) begin
        errors++; $display("FAIL rnd_casc i=%0d got %0d%0d ovf=%0b%0b expected %0d ovf=%0b%0b",
                           i, q1, q0, ov1, ov0, cn, co1, co0);
      end
    end
    clear = 1'b0; load = 1'b0; enable = 1'b0; c_clear = 1'b0; c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down();
    test_saturate();
    test_priority();
    test_async_reset();
    test_cascade();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
